// File: rtl/fan_pwm_capture_if.sv
// Bundles the PWM pin and the measurement results of fan_pwm_capture.
// Ports: pwm_in (raw pin), period/high_time (cycles), duty (0..127),
//        level (one-hot step), valid (update pulse), stuck, busy.
// master = the capture block, slave = the consumer / pin driver.
interface fan_pwm_capture_if #(
   parameter int CNT_W = 27
);
   logic             pwm_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic [6:0]       duty;
   logic [2:0]       level;
   logic             valid;
   logic             stuck;
   logic             busy;

   modport master (
      input  pwm_in,
      output period, high_time, duty, level, valid, stuck, busy
   );

   modport slave (
      output pwm_in,
      input  period, high_time, duty, level, valid, stuck, busy
   );
endinterface

// File: rtl/fan_pwm_capture.sv
// Purpose: measures period/high time of an incoming PWM pin, converts to a 7-bit duty + one-hot step, flags a stuck pin.
// Latency: results and a one-cycle valid appear 8 cycles after the rise pulse that closes a period.
// Backpressure: none; results are overwritten each period, periods closing while dividing are dropped.
// Ports: clk, reset_p (sync, active-high), bus (fan_pwm_capture_if.master).
module fan_pwm_capture #(
   parameter int SYS_CLK_FREQ   = 100_000_000,
   parameter int CNT_W          = 27,
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int MIN_PERIOD     = 16
) (
   input  logic               clk,
   input  logic               reset_p,
   fan_pwm_capture_if.master  bus
);

   if (SYS_CLK_FREQ <= 0) begin : g_bad_clk_freq
      $error("SYS_CLK_FREQ must be positive");
   end

   localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);

   typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

   state_t           state, state_nxt;
   logic             sync1, sync2, sync3;
   logic             rise, fall;
   logic [CNT_W-1:0] pcnt, hcnt;
   logic             fall_seen;
   logic [CNT_W-1:0] div_p, h_lat, rem;
   logic [6:0]       quo;
   logic [2:0]       iter;
   logic             launch, tmo_fire, div_done, tmo_hit;

   logic [CNT_W-1:0] period_r, high_r;
   logic [6:0]       duty_r;
   logic [2:0]       level_r;
   logic             valid_r, stuck_r;

   // Divider step. Dividend H*2^7 is never materialised: since H<P the
   // remainder stays below P, so shifting the remainder left once per
   // quotient bit is equivalent to the full-width restoring divider.
   logic [CNT_W:0]   rem_sh, rem_sub;
   logic             ge;
   logic [CNT_W-1:0] rem_nxt;
   logic [6:0]       quo_nxt;

   assign rise = sync2 & ~sync3;
   assign fall = ~sync2 & sync3;

   always_comb begin
      rem_sh  = {rem, 1'b0};
      rem_sub = rem_sh - {1'b0, div_p};
      ge      = ~rem_sub[CNT_W];         // non-negative difference: quotient bit is 1
      rem_nxt = ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      quo_nxt = {quo[5:0], ge};
   end

   function automatic logic [2:0] step_of(input logic [6:0] d);
      if (d < 7'd21)       return 3'b000;
      else if (d < 7'd63)  return 3'b001;
      else if (d < 7'd106) return 3'b010;
      else                 return 3'b100;
   endfunction

   // Timeout fires once: stuck blocks refiring while pcnt sits saturated.
   assign tmo_hit = (pcnt == TMO) && !stuck_r;

   always_ff @(posedge clk) begin
      if (reset_p) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      tmo_fire  = 1'b0;
      div_done  = 1'b0;
      case (state)
         IDLE: begin
            if (rise)         state_nxt = MEASURE;
            else if (tmo_hit) tmo_fire  = 1'b1;
         end
         MEASURE: begin
            if (rise) begin
               if (fall_seen && pcnt >= MINP) begin
                  launch    = 1'b1;
                  state_nxt = DIVIDE;
               end
            end else if (tmo_hit) begin
               tmo_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DIVIDE: begin
            if (iter == 3'd6) begin
               div_done  = 1'b1;
               state_nxt = MEASURE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync3     <= 1'b0;
         pcnt      <= '0;
         hcnt      <= '0;
         fall_seen <= 1'b0;
         div_p     <= '0;
         h_lat     <= '0;
         rem       <= '0;
         quo       <= '0;
         iter      <= '0;
         period_r  <= '0;
         high_r    <= '0;
         duty_r    <= '0;
         level_r   <= '0;
         valid_r   <= 1'b0;
         stuck_r   <= 1'b0;
      end else begin
         sync1 <= bus.pwm_in;
         sync2 <= sync1;
         sync3 <= sync2;

         // Counters restart on every rise, in every state.
         if (rise) begin
            pcnt      <= CNT_W'(1);
            hcnt      <= CNT_W'(1);
            fall_seen <= 1'b0;
         end else begin
            if (pcnt != TMO)          pcnt <= pcnt + 1'b1;
            if (sync2 && hcnt != TMO) hcnt <= hcnt + 1'b1;
            if (fall)                 fall_seen <= 1'b1;
         end

         valid_r <= 1'b0;

         if (launch) begin
            div_p <= pcnt;
            h_lat <= hcnt;
            rem   <= hcnt;
            quo   <= '0;
            iter  <= '0;
         end

         if (state == DIVIDE) begin
            rem  <= rem_nxt;
            quo  <= quo_nxt;
            iter <= iter + 3'd1;
         end

         if (div_done) begin
            period_r <= div_p;
            high_r   <= h_lat;
            duty_r   <= quo_nxt;
            level_r  <= step_of(quo_nxt);
            valid_r  <= 1'b1;
         end

         if (tmo_fire) begin
            stuck_r  <= 1'b1;
            period_r <= '0;
            high_r   <= '0;
            duty_r   <= sync2 ? 7'd127 : 7'd0;
            level_r  <= sync2 ? 3'b100 : 3'b000;
            valid_r  <= 1'b1;
         end

         if (state == IDLE && rise) stuck_r <= 1'b0;
      end
   end

   assign bus.period    = period_r;
   assign bus.high_time = high_r;
   assign bus.duty      = duty_r;
   assign bus.level     = level_r;
   assign bus.valid     = valid_r;
   assign bus.stuck     = stuck_r;
   assign bus.busy      = (state == DIVIDE);

endmodule
